// File: rtl/coproc_uart_ctrl.sv
// coproc_uart_ctrl: assembles header/A/B frames from UART words, runs the co-processor, returns status and result.
// Any protocol violation (bad sync, idle timeout, stray word, exec timeout) bumps a saturating error counter.
module coproc_uart_ctrl #(
    parameter int DATA_WIDTH   = 24,
    parameter int NUM_OPS      = 8,
    parameter int RX_TIMEOUT   = 1_000_000,
    parameter int EXEC_TIMEOUT = 65_536
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic                  o_exec_start,
    output logic [3:0]            o_exec_op,
    output logic [DATA_WIDTH-1:0] o_exec_a,
    output logic [DATA_WIDTH-1:0] o_exec_b,
    input  logic                  i_exec_done,
    input  logic [DATA_WIDTH-1:0] i_exec_result,
    output logic                  o_tx_valid,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic [7:0]            o_err_cnt
);
    localparam int TMAX = RX_TIMEOUT > EXEC_TIMEOUT ? RX_TIMEOUT : EXEC_TIMEOUT;
    localparam int TW = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] RX_LAST = TW'(RX_TIMEOUT - 1);
    localparam logic [TW-1:0] EX_LAST = TW'(EXEC_TIMEOUT - 1);
    localparam logic [4:0] NOPS = 5'(NUM_OPS);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, WAIT, TX_STAT, TX_RES} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [3:0]            op_q, op_d, stat_q, stat_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [7:0]            err_q, err_d;
    logic                  err_inc, hs;

    assign o_exec_start = state_q == EXEC;
    assign o_exec_op    = op_q;
    assign o_exec_a     = a_q;
    assign o_exec_b     = b_q;
    assign o_busy       = state_q != IDLE;
    assign o_err_cnt    = err_q;
    assign o_tx_valid   = state_q == TX_STAT || state_q == TX_RES;
    assign o_tx_data    = state_q == TX_STAT ? DATA_WIDTH'({8'h5A, 4'h0, stat_q, 4'h0, op_q}) :
                          state_q == TX_RES  ? res_q : '0;
    assign hs           = o_tx_valid && i_tx_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        stat_d  = stat_q;
        err_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rx_done && i_rx_data[23:16] == 8'hA5) begin
                    op_d    = i_rx_data[15:12];
                    state_d = GET_A;
                end else begin
                    err_inc = i_rx_done;
                end
            end
            GET_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = GET_B;
                end else if (tmr_q == RX_LAST) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    b_d = i_rx_data;
                    if ({1'b0, op_q} < NOPS) begin
                        state_d = EXEC;
                    end else begin
                        stat_d  = 4'd1;
                        res_d   = '0;
                        state_d = TX_STAT;
                    end
                end else if (tmr_q == RX_LAST) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                err_inc = i_rx_done;
                state_d = WAIT;
            end
            WAIT: begin
                err_inc = i_rx_done;
                if (i_exec_done) begin
                    res_d   = i_exec_result;
                    stat_d  = 4'd0;
                    state_d = TX_STAT;
                end else if (tmr_q == EX_LAST) begin
                    res_d   = '0;
                    stat_d  = 4'd2;
                    err_inc = 1'b1;
                    state_d = TX_STAT;
                end
            end
            TX_STAT: begin
                err_inc = i_rx_done;
                state_d = hs ? TX_RES : TX_STAT;
            end
            TX_RES: begin
                err_inc = i_rx_done;
                state_d = hs ? IDLE : TX_RES;
            end
            default: state_d = IDLE;
        endcase
    end

    // timer counts cycles spent in the current state; zero on the first cycle after entry
    assign tmr_d = (state_d != state_q || state_q == IDLE) ? '0 : tmr_q + TW'(1);
    assign err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            op_q    <= '0;
            stat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            op_q    <= op_d;
            stat_q  <= stat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_coproc_uart_ctrl.sv
// tb_coproc_uart_ctrl: directed frames against coproc_uart_ctrl with a small execution-unit model.
module tb_coproc_uart_ctrl;
    logic        clk, rst;
    logic        rx_done;
    logic [23:0] rx_data;
    logic        exec_start;
    logic [3:0]  exec_op;
    logic [23:0] exec_a, exec_b;
    logic        exec_done;
    logic [23:0] exec_result;
    logic        tx_valid;
    logic [23:0] tx_data;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int exec_lat = 3;
    logic [23:0] exec_val = 24'h0;

    coproc_uart_ctrl #(
        .DATA_WIDTH(24), .NUM_OPS(8), .RX_TIMEOUT(32), .EXEC_TIMEOUT(16)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_exec_start(exec_start), .o_exec_op(exec_op),
        .o_exec_a(exec_a), .o_exec_b(exec_b),
        .i_exec_done(exec_done), .i_exec_result(exec_result),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_err_cnt(err_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    // execution unit: answers exec_lat cycles after start, never if exec_lat == 0
    initial begin
        exec_done = 0;
        exec_result = '0;
        forever begin
            @(negedge clk);
            if (exec_start) begin
                n_start++;
                if (exec_lat > 0) begin
                    repeat (exec_lat) @(negedge clk);
                    exec_done = 1;
                    exec_result = exec_val;
                    @(negedge clk);
                    exec_done = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] w);
        rx_done = 1;
        rx_data = w;
        @(negedge clk);
        rx_done = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic expect_tx(input string tag, input logic [23:0] exp);
        for (int i = 0; i < 60 && !tx_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        chk({tag, "_data"}, {8'd0, tx_data}, {8'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        rx_done = 0;
        rx_data = '0;
        tx_ready = 1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {24'd0, err_cnt}, 0);
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_start", {31'd0, exec_start}, 0);
        chk("rst_data", {8'd0, tx_data}, 0);
        rst = 0;

        exec_lat = 3;
        exec_val = 24'h00000C;
        send(24'hA53000);
        send(24'h000005);
        send(24'h000007);
        chk("t1_start", {31'd0, exec_start}, 1);
        chk("t1_op", {28'd0, exec_op}, 3);
        chk("t1_a", {8'd0, exec_a}, 5);
        chk("t1_b", {8'd0, exec_b}, 7);
        expect_tx("t1_stat", 24'h5A0003);
        expect_tx("t1_res", 24'h00000C);
        chk("t1_idle_valid", {31'd0, tx_valid}, 0);
        chk("t1_err", {24'd0, err_cnt}, 0);

        do_reset();
        send(24'h123000);
        chk("t2_busy", {31'd0, busy}, 0);
        chk("t2_err", {24'd0, err_cnt}, 1);
        exec_val = 24'h000055;
        send(24'hA51000);
        send(24'h000002);
        send(24'h000003);
        chk("t2_start", {31'd0, exec_start}, 1);
        expect_tx("t2_stat", 24'h5A0001);
        expect_tx("t2_res", 24'h000055);
        chk("t2_err_after", {24'd0, err_cnt}, 1);

        do_reset();
        n_start = 0;
        send(24'hA59000);
        send(24'h000011);
        send(24'h000022);
        chk("t3_nostart", {31'd0, exec_start}, 0);
        expect_tx("t3_stat", 24'h5A0109);
        expect_tx("t3_res", 24'h000000);
        chk("t3_nstart", n_start, 0);
        chk("t3_err", {24'd0, err_cnt}, 0);

        do_reset();
        exec_lat = 0;
        send(24'hA53000);
        send(24'h000001);
        send(24'h000002);
        repeat (16) @(negedge clk);
        chk("t4_wait_last", {31'd0, tx_valid}, 0);
        @(negedge clk);
        expect_tx("t4_stat", 24'h5A0203);
        expect_tx("t4_res", 24'h000000);
        chk("t4_err", {24'd0, err_cnt}, 1);

        do_reset();
        send(24'hA52000);
        repeat (31) @(negedge clk);
        chk("t5_busy_last", {31'd0, busy}, 1);
        @(negedge clk);
        chk("t5_busy_to", {31'd0, busy}, 0);
        chk("t5_err", {24'd0, err_cnt}, 1);
        chk("t5_valid", {31'd0, tx_valid}, 0);

        do_reset();
        exec_lat = 3;
        exec_val = 24'h000077;
        tx_ready = 0;
        send(24'hA54000);
        send(24'h000001);
        send(24'h000002);
        @(negedge clk);
        send(24'hABCDEF);
        for (int i = 0; i < 60 && !tx_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("t6_hold_valid", {31'd0, tx_valid}, 1);
            chk("t6_hold_data", {8'd0, tx_data}, 32'h5A0004);
            @(negedge clk);
        end
        tx_ready = 1;
        @(negedge clk);
        chk("t6_res_valid", {31'd0, tx_valid}, 1);
        chk("t6_res_data", {8'd0, tx_data}, 32'h000077);
        chk("t6_err", {24'd0, err_cnt}, 1);
        chk("t6_a", {8'd0, exec_a}, 1);
        tx_ready = 0;
        rst = 1;
        #1;
        chk("t6_rst_valid", {31'd0, tx_valid}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 0;
        tx_ready = 1;

        for (int i = 0; i < 260; i++) send(24'h000000);
        chk("t7_sat", {24'd0, err_cnt}, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/coproc_uart_ctrl.md
Name: coproc_uart_ctrl

Overview:
- Command sequencer between the 24-bit UART receiver, the co-processor execution unit and the UART transmitter.
- Assembles a three-word command frame from received words: a header, then operand A, then operand B.
- Issues the operation to the execution unit and waits for its result, with a timeout.
- Returns a status word and a result word through the transmitter using a valid/ready handshake.

Parameters:
- DATA_WIDTH, 24, width of UART words and operands (fixed frame layout assumes 24).
- NUM_OPS, 8, number of valid opcodes; opcode >= NUM_OPS is rejected.
- RX_TIMEOUT, 1_000_000, max idle cycles between frame words before the frame is aborted.
- EXEC_TIMEOUT, 65_536, max cycles waiting for i_exec_done.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_done  in  1  one-cycle pulse; i_rx_data valid this cycle.
- i_rx_data  in  DATA_WIDTH  received word.
- o_exec_start  out  1  one-cycle start pulse to the execution unit.
- o_exec_op  out  4  opcode, stable from start until the result is latched.
- o_exec_a  out  DATA_WIDTH  operand A, stable likewise.
- o_exec_b  out  DATA_WIDTH  operand B, stable likewise.
- i_exec_done  in  1  one-cycle pulse; i_exec_result valid this cycle.
- i_exec_result  in  DATA_WIDTH  execution result.
- o_tx_valid  out  1  o_tx_data valid for the transmitter.
- o_tx_data  out  DATA_WIDTH  word to transmit.
- i_tx_ready  in  1  transmitter accepts a word when o_tx_valid && i_tx_ready at a rising edge.
- o_busy  out  1  high whenever state != IDLE.
- o_err_cnt  out  8  saturating count of protocol errors.

Behaviour:
- Reset (async, immediate): state IDLE. o_exec_start=0, o_tx_valid=0, o_busy=0, o_err_cnt=0; o_exec_op/a/b=0, o_tx_data=0. Internal timers cleared. Reset mid-frame or mid-transmit abandons everything; no partial word is re-sent.
- Header layout: [23:16] sync byte, must be 8'hA5; [15:12] opcode; [11:0] ignored.
- States and transitions:
  - IDLE:
    - i_rx_done with sync==A5: latch opcode, go GET_A.
    - i_rx_done with bad sync: o_err_cnt++, stay in IDLE.
  - GET_A:
    - i_rx_done: latch operand A, clear timer, go GET_B.
    - Timer reaches RX_TIMEOUT: o_err_cnt++, go IDLE.
  - GET_B:
    - i_rx_done: latch operand B.
    - Opcode < NUM_OPS: go EXEC.
    - Opcode invalid: status=1, result=0, go TX_STAT.
    - Timer reaches RX_TIMEOUT: o_err_cnt++, go IDLE.
  - EXEC: exactly one cycle; o_exec_start=1; go WAIT. i_exec_done is ignored in this cycle (execution unit latency >= 1).
  - WAIT:
    - i_exec_done: latch i_exec_result, status=0, go TX_STAT.
    - Timer reaches EXEC_TIMEOUT: status=2, result=0, o_err_cnt++, go TX_STAT.
  - TX_STAT:
    - o_tx_valid=1, o_tx_data={8'h5A, 4'h0, status[3:0], 4'h0, opcode[3:0]}.
    - On handshake: go TX_RES.
  - TX_RES:
    - o_tx_valid=1, o_tx_data=result.
    - On handshake: go IDLE.
- Timers reset on every state entry. Timeout fires on the cycle the count equals the limit.
- o_tx_valid and o_tx_data are held constant until the handshake; valid never drops without a handshake. o_tx_valid is low in all other states.
- After the result handshake, o_tx_valid is 0 the next cycle (IDLE).
- i_rx_done in EXEC, WAIT, TX_STAT or TX_RES: word dropped, o_err_cnt++.
- i_exec_done outside WAIT: ignored.
- o_err_cnt saturates at 255. Multiple error conditions in one cycle increment it by 1 only.
- Latency:
  - Last operand rx_done to o_exec_start: 1 cycle.
  - i_exec_done to o_tx_valid: 1 cycle.
  - Status handshake to result valid: 1 cycle, with no bubble beyond the state change.

Test Plan:
- Frame A53000, 000005, 000007 with the exec model returning 00000C after 3 cycles, i_tx_ready=1 → o_exec_start one cycle after the 3rd word with op=3, a=5, b=7. TX words 5A0003 then 00000C. o_err_cnt=0.
- Header 123000 → stays IDLE, o_busy=0, o_err_cnt=1. A following valid frame is then processed normally.
- Frame A59000, x, y with NUM_OPS=8 → no o_exec_start. TX words 5A0109 then 000000.
- Valid frame, exec model never responds → after EXEC_TIMEOUT (bench uses 16): TX words 5A0203 then 000000; o_err_cnt=1.
- Header only, then silence (bench RX_TIMEOUT=32) → IDLE after 32 cycles, o_err_cnt=1, no TX.
- i_tx_ready held low for 10 cycles during TX_STAT, plus an extra rx_done during WAIT → o_tx_valid/o_tx_data stable for all 10 cycles. The stray word is dropped and o_err_cnt increments. Asserting i_rst mid-TX_RES clears o_tx_valid immediately.
